// File: rtl/alu_mul_seq.sv
// Purpose : builds a full DATA_WIDTH x DATA_WIDTH -> 2*DATA_WIDTH product by issuing four
//           HALF x HALF multiplies on the shared ALU and accumulating the partial products.
// Latency : response 5 cycles after the accept edge (unsigned), 7 with signed correction.
// Backpr. : one request at a time; req_ready only in IDLE; DONE holds the result until resp_ready.
//
// Optional feature: define ALU_MUL_SIGNED_EN to honour req_signed (two's-complement product).
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   req_valid/req_ready     request handshake; req_a, req_b operands, req_signed flag
//   resp_valid/resp_ready   response handshake; resp_hi/resp_lo = product halves
//   alu_busy                sequencer owns the ALU inputs this cycle
//   alu_SrcA/alu_SrcB       ALU operands driven by the sequencer
//   alu_Operation           ALU opcode driven by the sequencer
//   alu_ALUResult           combinational ALU result, consumed in the same cycle
module alu_mul_seq #(
    parameter int                         DATA_WIDTH    = 32,
    parameter int                         OPCODE_LENGTH = 5,
    parameter logic [OPCODE_LENGTH-1:0]   OP_MUL16      = 5'b10010,
    parameter logic [OPCODE_LENGTH-1:0]   OP_SUB        = 5'b00110
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [DATA_WIDTH-1:0]     req_a,
    input  logic [DATA_WIDTH-1:0]     req_b,
    input  logic                      req_signed,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [DATA_WIDTH-1:0]     resp_hi,
    output logic [DATA_WIDTH-1:0]     resp_lo,
    output logic                      alu_busy,
    output logic [DATA_WIDTH-1:0]     alu_SrcA,
    output logic [DATA_WIDTH-1:0]     alu_SrcB,
    output logic [OPCODE_LENGTH-1:0]  alu_Operation,
    input  logic [DATA_WIDTH-1:0]     alu_ALUResult
);

    localparam int HALF = DATA_WIDTH / 2;
    localparam int AW   = 2 * DATA_WIDTH;

`ifdef ALU_MUL_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE, PP0, PP1, PP2, PP3, CORR_A, CORR_B, DONE
    } state_t;

    state_t               state, state_nxt;
    logic [DATA_WIDTH-1:0] a_q, b_q;
    logic                  signed_q;
    logic [AW-1:0]         acc;
    logic [AW-1:0]         pp_ext;

    // A HALF x HALF product always fits in DATA_WIDTH bits, so zero-extension is exact.
    assign pp_ext  = {{DATA_WIDTH{1'b0}}, alu_ALUResult};
    assign resp_hi = acc[AW-1:DATA_WIDTH];
    assign resp_lo = acc[DATA_WIDTH-1:0];

    always_comb begin
        state_nxt     = state;
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        alu_busy      = 1'b0;
        alu_SrcA      = '0;
        alu_SrcB      = '0;
        alu_Operation = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = PP0;
            end
            PP0: begin
                alu_busy      = 1'b1;
                alu_SrcA      = {{HALF{1'b0}}, a_q[HALF-1:0]};
                alu_SrcB      = {{HALF{1'b0}}, b_q[HALF-1:0]};
                alu_Operation = OP_MUL16;
                state_nxt     = PP1;
            end
            PP1: begin
                alu_busy      = 1'b1;
                alu_SrcA      = {{HALF{1'b0}}, a_q[HALF-1:0]};
                alu_SrcB      = {{HALF{1'b0}}, b_q[DATA_WIDTH-1:HALF]};
                alu_Operation = OP_MUL16;
                state_nxt     = PP2;
            end
            PP2: begin
                alu_busy      = 1'b1;
                alu_SrcA      = {{HALF{1'b0}}, a_q[DATA_WIDTH-1:HALF]};
                alu_SrcB      = {{HALF{1'b0}}, b_q[HALF-1:0]};
                alu_Operation = OP_MUL16;
                state_nxt     = PP3;
            end
            PP3: begin
                alu_busy      = 1'b1;
                alu_SrcA      = {{HALF{1'b0}}, a_q[DATA_WIDTH-1:HALF]};
                alu_SrcB      = {{HALF{1'b0}}, b_q[DATA_WIDTH-1:HALF]};
                alu_Operation = OP_MUL16;
                state_nxt     = (signed_q && SIGNED_EN) ? CORR_A : DONE;
            end
            // Signed product = unsigned product - (a<0 ? b<<W : 0) - (b<0 ? a<<W : 0), mod 2^(2W).
            CORR_A: begin
                alu_busy      = 1'b1;
                alu_SrcA      = acc[AW-1:DATA_WIDTH];
                alu_SrcB      = a_q[DATA_WIDTH-1] ? b_q : '0;
                alu_Operation = OP_SUB;
                state_nxt     = CORR_B;
            end
            CORR_B: begin
                alu_busy      = 1'b1;
                alu_SrcA      = acc[AW-1:DATA_WIDTH];
                alu_SrcB      = b_q[DATA_WIDTH-1] ? a_q : '0;
                alu_Operation = OP_SUB;
                state_nxt     = DONE;
            end
            DONE: begin
                resp_valid = 1'b1;
                if (resp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            signed_q <= 1'b0;
            acc      <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        a_q      <= req_a;
                        b_q      <= req_b;
                        signed_q <= req_signed;
                        acc      <= '0;
                    end
                end
                PP0:           acc <= acc + pp_ext;
                PP1, PP2:      acc <= acc + (pp_ext << HALF);
                PP3:           acc <= acc + (pp_ext << DATA_WIDTH);
                CORR_A, CORR_B: acc[AW-1:DATA_WIDTH] <= alu_ALUResult;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mul_seq.sv
module tb_alu_mul_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready;
    logic [31:0] req_a, req_b;
    logic        req_signed;
    logic        resp_valid, resp_ready;
    logic [31:0] resp_hi, resp_lo;
    logic        alu_busy;
    logic [31:0] alu_SrcA, alu_SrcB;
    logic [4:0]  alu_Operation;
    logic [31:0] alu_ALUResult;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Behavioural stand-in for the shared combinational ALU.
    always_comb begin
        alu_ALUResult = 32'h0;
        if (alu_Operation == 5'b10010)
            alu_ALUResult = {16'h0, alu_SrcA[15:0]} * {16'h0, alu_SrcB[15:0]};
        else if (alu_Operation == 5'b00110)
            alu_ALUResult = alu_SrcA - alu_SrcB;
    end

    alu_mul_seq dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_signed(req_signed),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_hi(resp_hi), .resp_lo(resp_lo),
        .alu_busy(alu_busy), .alu_SrcA(alu_SrcA), .alu_SrcB(alu_SrcB),
        .alu_Operation(alu_Operation), .alu_ALUResult(alu_ALUResult)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one request from IDLE (called #1 after an edge), follow it to resp_valid.
    // With rr=1 the response is consumed and the return to IDLE is checked.
    task automatic run_req(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic s, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                           input int exp_lat, input logic rr);
        int cyc;
        resp_ready = rr;
        req_a      = a;
        req_b      = b;
        req_signed = s;
        req_valid  = 1'b1;
        chk({tag, "_req_ready"}, req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        cyc = 1;
        while (!resp_valid && cyc < 20) begin
            chk({tag, "_op"}, alu_Operation, (cyc <= 4) ? 5'h12 : 5'h06);
            chk({tag, "_busy"}, alu_busy, 1);
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, "_latency"}, cyc, exp_lat);
        chk({tag, "_hi"}, resp_hi, exp_hi);
        chk({tag, "_lo"}, resp_lo, exp_lo);
        chk({tag, "_busy_done"}, alu_busy, 0);
        if (rr) begin
            @(posedge clk); #1;
            chk({tag, "_back_idle"}, {req_ready, resp_valid}, 2'b10);
        end
    endtask

    initial begin
        int idle_at[$];
        int bad;
        int k;

        reset = 1'b1; req_valid = 1'b0; req_a = 0; req_b = 0;
        req_signed = 1'b0; resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset values
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp", {resp_hi, resp_lo}, 64'h0);
        chk("rst_busy", alu_busy, 0);
        chk("rst_srcs", {alu_SrcA, alu_SrcB}, 64'h0);
        chk("rst_op", alu_Operation, 0);

        // Unsigned directed vectors
        run_req("max", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001, 5, 1'b1);
        run_req("p16", 32'h00010000, 32'h00010000, 1'b0, 32'h00000001, 32'h00000000, 5, 1'b1);
        run_req("zero", 32'h0, 32'h12345678, 1'b0, 32'h0, 32'h0, 5, 1'b1);
        run_req("mix", 32'h12345678, 32'h9ABCDEF0, 1'b0, 32'h0B00EA4E, 32'h242D2080, 5, 1'b1);

`ifdef ALU_MUL_SIGNED_EN
        run_req("s_m1", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h0, 32'h1, 7, 1'b1);
        run_req("s_m2x3", 32'hFFFFFFFE, 32'h3, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFA, 7, 1'b1);
`else
        // Without the feature req_signed is ignored: plain unsigned product.
        run_req("s_ign", 32'hFFFFFFFE, 32'h3, 1'b1, 32'h00000002, 32'hFFFFFFFA, 5, 1'b1);
`endif

        // Backpressure: DONE held for 3 cycles, req_valid pulse must not be taken.
        run_req("bp", 32'h00001234, 32'h00010001, 1'b0, 32'h0, 32'h12341234, 5, 1'b0);
        req_a = 32'hDEAD; req_b = 32'hBEEF; req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", resp_valid, 1);
            chk("bp_resp", {resp_hi, resp_lo}, 64'h0000000012341234);
            chk("bp_req_ready", req_ready, 0);
            chk("bp_busy", alu_busy, 0);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release", {req_ready, resp_valid, alu_busy}, 3'b100);
        @(posedge clk); #1;
        chk("bp_no_accept", {req_ready, alu_busy}, 2'b10);

        // Reset during PP2 discards the partial product.
        req_a = 32'hFFFFFFFF; req_b = 32'hFFFFFFFF; req_signed = 1'b0; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pp2_srcA", alu_SrcA, 32'h0000FFFF);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("mid_rst_state", {req_ready, resp_valid, alu_busy}, 3'b100);
        chk("mid_rst_op", alu_Operation, 0);
        chk("mid_rst_acc", {resp_hi, resp_lo}, 64'h0);
        run_req("after_rst", 32'h3, 32'h5, 1'b0, 32'h0, 32'hF, 5, 1'b1);

        // Back-to-back with resp_ready tied high and req_valid held.
        resp_ready = 1'b1; req_a = 32'd7; req_b = 32'd9; req_signed = 1'b0; req_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 18; i++) begin
            if (req_ready) idle_at.push_back(i);
            if ((req_ready || resp_valid) && alu_busy) bad++;
            if (resp_valid) chk("b2b_lo", resp_lo, 32'd63);
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        chk("b2b_busy_idle_done", bad, 0);
        chk("b2b_accepts", idle_at.size() >= 3, 1);
        if (idle_at.size() >= 3) begin
            chk("b2b_gap0", idle_at[1] - idle_at[0], 6);
            chk("b2b_gap1", idle_at[2] - idle_at[1], 6);
        end
        k = 0;
        while (!req_ready && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk("drain", req_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_mul_seq.md
# alu_mul_seq

Multi-cycle sequencer that builds a full 32x32 -> 64-bit product by driving the shared ALU's 16-bit multiply operation (opcode 5'b10010) four times and accumulating the partial products internally. It sits beside the ALU in the execute stage. While busy it owns the ALU operand/opcode inputs, and the core stalls on `alu_busy`. It takes one request at a time over a valid/ready handshake and returns the 64-bit result over a valid/ready handshake.

## Interface
- DATA_WIDTH, 32: operand width; HALF = DATA_WIDTH/2 (must be even)
- OPCODE_LENGTH, 5: ALU opcode width
- OP_MUL16, 5'b10010: ALU opcode for unsigned HALF x HALF multiply
- OP_SUB, 5'b00110: ALU opcode for subtract (signed correction only)

- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request (IDLE only)
- req_a  in  DATA_WIDTH  multiplicand
- req_b  in  DATA_WIDTH  multiplier
- req_signed  in  1  signed x signed request (used only with ALU_MUL_SIGNED_EN)
- resp_valid  out  1  result available
- resp_ready  in  1  consumer takes the result
- resp_hi  out  DATA_WIDTH  product[63:32]
- resp_lo  out  DATA_WIDTH  product[31:0]
- alu_busy  out  1  sequencer owns the ALU; the core muxes the ALU inputs to alu_SrcA/alu_SrcB/alu_Operation
- alu_SrcA  out  DATA_WIDTH  ALU operand A
- alu_SrcB  out  DATA_WIDTH  ALU operand B
- alu_Operation  out  OPCODE_LENGTH  ALU opcode
- alu_ALUResult  in  DATA_WIDTH  combinational ALU result, sampled in the same cycle

## Operation
- States: IDLE, PP0, PP1, PP2, PP3, CORR_A, CORR_B, DONE.
- IDLE:
  - req_ready=1.
  - When req_valid=1, latch a and b, latch the signed flag, clear the 128-bit-free 64-bit accumulator acc, and go to PP0.
- PPk, for (i,j) = (0,0), (0,1), (1,0), (1,1):
  - alu_SrcA = zero-extended a half i; alu_SrcB = zero-extended b half j; alu_Operation = OP_MUL16.
  - Update: acc <= acc + (alu_ALUResult << (HALF*(i+j))), all 64-bit modulo arithmetic.
  - PP0->PP1->PP2->PP3 unconditionally.
- After PP3:
  - Go to CORR_A if the latched signed flag is 1 and the macro is defined.
  - Otherwise go to DONE.
- CORR_A:
  - SrcA = acc[63:32]; SrcB = a[31] ? b : 0; Operation = OP_SUB.
  - acc[63:32] <= alu_ALUResult. Go to CORR_B.
- CORR_B:
  - Same as CORR_A with SrcB = b[31] ? a : 0.
  - Go to DONE.
- DONE:
  - resp_valid=1; resp_hi/resp_lo = acc, held stable.
  - When resp_ready=1, go to IDLE.
- alu_busy=1 in PP0..CORR_B; 0 in IDLE and DONE. When alu_busy=0, ALU outputs are 0 / OP opcode 0.
- Requests are never queued. req_valid while not IDLE is ignored (req_ready=0); the requester must hold it.

## Timing
- Reset values: state=IDLE, req_ready=1 after reset deasserts, resp_valid=0, resp_hi=resp_lo=0, alu_busy=0, alu_SrcA=alu_SrcB=0, alu_Operation=0, acc=0.
- Cycle 0 is the accept edge. Latency is counted from that edge to the first cycle with resp_valid=1:
  - Unsigned: resp_valid=1 in cycle 5.
  - Signed (macro on): resp_valid=1 in cycle 7.
- The ALU is purely combinational. Each PP/CORR state takes exactly one cycle, with no wait states.
- resp_valid and resp_ready high in the same cycle: IDLE next cycle, so there is one bubble between back-to-back requests.
- resp_ready low: DONE holds indefinitely with the outputs unchanged.
- reset asserted in any state, including mid-PP: next cycle is IDLE with all reset values. Any partial result is discarded and no resp_valid is produced.
- Zero operands still run all states, giving fixed latency.

## Configuration
- ALU_MUL_SIGNED_EN defined:
  - req_signed is honored; signed requests pass through CORR_A/CORR_B, yielding the two's-complement 64-bit signed product.
- Not defined:
  - req_signed is ignored and CORR_A/CORR_B are unreachable (may be removed).
  - OP_SUB is never issued; all products are unsigned.

## Test plan
- Unsigned 0xFFFFFFFF x 0xFFFFFFFF -> resp_hi=0xFFFFFFFE, resp_lo=0x00000001, resp_valid in cycle 5; alu_Operation=0x12 in cycles 1-4.
- Unsigned 0x00010000 x 0x00010000 -> hi=0x00000001, lo=0x00000000. Unsigned 0 x 0x12345678 -> 0/0, same latency.
- Signed (macro on) -1 x -1 -> hi=0, lo=1. Signed 0xFFFFFFFE x 3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA, resp_valid in cycle 7, OP_SUB in cycles 5-6.
- Backpressure: hold resp_ready=0 for 3 cycles after resp_valid. Outputs stay stable and req_ready=0; a req_valid pulse during DONE is not accepted.
- Assert reset during PP2 -> next cycle IDLE, req_ready=1, resp_valid=0, alu_busy=0. A new request 0x3 x 0x5 then returns hi=0, lo=0xF.
- Back-to-back: resp_ready tied 1 with req_valid held. Accepts occur 6 cycles apart (unsigned), and alu_busy is low in IDLE/DONE.
